// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
// Bundles the IFU, LSU and RAM-side signals of the shared 64-bit data RAM
// port. The arbiter connects through the slave modport; the environment
// (requesters plus RAM) uses the master modport.
//
// Signals:
//   if_req_i / if_addr_i                 IFU read request and byte address
//   if_gnt_o / if_rvalid_o / if_rdata_o  IFU accept, read-return valid/data
//   ls_req_i / ls_wen_i / ls_addr_i      LSU request, write flag, address
//   ls_byte_en_i / ls_wdata_i            LSU write byte enables and data
//   ls_gnt_o / ls_rvalid_o / ls_rdata_o  LSU accept, read-return valid/data
//   ram_addr_o / ram_ren_o / ram_wen_o   RAM address and enables
//   ram_byte_en_o / ram_wdata_o          RAM write byte enables and data
//   ram_rdata_i                          RAM read data
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
    parameter int unsigned XLEN = 64
);
    logic            if_req_i;
    logic [XLEN-1:0] if_addr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [XLEN-1:0] if_rdata_o;

    logic            ls_req_i;
    logic            ls_wen_i;
    logic [XLEN-1:0] ls_addr_i;
    logic [7:0]      ls_byte_en_i;
    logic [XLEN-1:0] ls_wdata_i;
    logic            ls_gnt_o;
    logic            ls_rvalid_o;
    logic [XLEN-1:0] ls_rdata_o;

    logic [XLEN-1:0] ram_addr_o;
    logic            ram_ren_o;
    logic            ram_wen_o;
    logic [7:0]      ram_byte_en_o;
    logic [XLEN-1:0] ram_wdata_o;
    logic [XLEN-1:0] ram_rdata_i;

    // Arbiter view
    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_wen_i, ls_addr_i, ls_byte_en_i, ls_wdata_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output ram_addr_o, ram_ren_o, ram_wen_o, ram_byte_en_o, ram_wdata_o,
        input  ram_rdata_i
    );

    // Requester / RAM view
    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_wen_i, ls_addr_i, ls_byte_en_i, ls_wdata_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  ram_addr_o, ram_ren_o, ram_wen_o, ram_byte_en_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares the single 64-bit data RAM port between instruction fetch (read
// only) and the load/store unit. One same-cycle req/gnt per cycle; the
// winner drives the RAM port. A {valid, owner} shift pipeline of RD_LATENCY
// stages routes each read return back to the requester that issued it.
//
// Parameters:
//   XLEN        data/address width (64)
//   RD_LATENCY  cycles from ram_ren_o to ram_rdata_i valid, legal 1..4
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    ram_port_arbiter_if.slave (IFU, LSU and RAM signals)
//
// Build option:
//   ARB_LSU_PRIO_EN  when defined the LSU always wins contention and the
//                    round-robin pointer is removed; otherwise round-robin.
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_port_arbiter_if.slave  bus
);

    localparam int unsigned BE_W   = 8;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned PIPE_W = 2 * RD_LATENCY;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef struct packed {
        logic vld;
        logic own;
    } stage_t;

    logic            w_if_req;
    logic            w_ls_req;
    logic            w_if_gnt;
    logic            w_ls_gnt;
    logic            w_owner;
    logic            w_ren;
    logic            w_wen;
    logic [XLEN-1:0] w_addr;
    logic [BE_W-1:0] w_be;
    logic [XLEN-1:0] w_wdata;
    stage_t          w_stage0;
    stage_t          w_tail;
    logic            w_if_rvalid;
    logic            w_ls_rvalid;
    logic            w_unused_addr_lsb;

    stage_t [RD_LATENCY-1:0] r_pipe;

    // Requests are masked while in reset so every output reads 0
    assign w_if_req = bus.if_req_i & rst_n;
    assign w_ls_req = bus.ls_req_i & rst_n;

    // Word-aligned RAM port: the byte offset bits are intentionally ignored
    assign w_unused_addr_lsb = ^{bus.if_addr_i[OFF_W-1:0], bus.ls_addr_i[OFF_W-1:0]};

`ifdef ARB_LSU_PRIO_EN
    // Fixed priority: the mem stage stalls the pipeline, so LSU always wins
    always_comb begin
        w_if_gnt = 1'b0;
        w_ls_gnt = 1'b0;
        if (w_ls_req) begin
            w_ls_gnt = 1'b1;
        end else if (w_if_req) begin
            w_if_gnt = 1'b1;
        end
    end
`else
    logic r_rr_ptr;

    // Round-robin: rr_ptr names the requester preferred on contention
    always_comb begin
        w_if_gnt = 1'b0;
        w_ls_gnt = 1'b0;
        if (w_if_req && w_ls_req) begin
            if (r_rr_ptr == OWN_LSU) begin
                w_ls_gnt = 1'b1;
            end else begin
                w_if_gnt = 1'b1;
            end
        end else if (w_if_req) begin
            w_if_gnt = 1'b1;
        end else if (w_ls_req) begin
            w_ls_gnt = 1'b1;
        end
    end

    // Pointer moves to the loser of every granted cycle, holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= OWN_IFU;
        end else if (w_if_gnt) begin
            r_rr_ptr <= OWN_LSU;
        end else if (w_ls_gnt) begin
            r_rr_ptr <= OWN_IFU;
        end
    end
`endif

    // RAM port drive from the winner; everything 0 when nobody is granted
    always_comb begin
        w_owner = OWN_IFU;
        w_ren   = 1'b0;
        w_wen   = 1'b0;
        w_addr  = '0;
        w_be    = '0;
        w_wdata = '0;
        if (w_if_gnt) begin
            w_ren  = 1'b1;
            w_addr = {bus.if_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
        end else if (w_ls_gnt) begin
            w_owner = OWN_LSU;
            w_addr  = {bus.ls_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            if (bus.ls_wen_i) begin
                w_wen   = 1'b1;
                w_be    = bus.ls_byte_en_i;
                w_wdata = bus.ls_wdata_i;
            end else begin
                w_ren = 1'b1;
            end
        end
    end

    assign w_stage0.vld = w_ren;
    assign w_stage0.own = w_owner;

    // Read-return tracker; new stage enters at index 0, response leaves the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= PIPE_W'({r_pipe, w_stage0});
        end
    end

    assign w_tail      = r_pipe[RD_LATENCY-1];
    assign w_if_rvalid = w_tail.vld && (w_tail.own == OWN_IFU);
    assign w_ls_rvalid = w_tail.vld && (w_tail.own == OWN_LSU);

    assign bus.if_gnt_o      = w_if_gnt;
    assign bus.ls_gnt_o      = w_ls_gnt;
    assign bus.ram_ren_o     = w_ren;
    assign bus.ram_wen_o     = w_wen;
    assign bus.ram_addr_o    = w_addr;
    assign bus.ram_byte_en_o = w_be;
    assign bus.ram_wdata_o   = w_wdata;

    assign bus.if_rvalid_o = w_if_rvalid;
    assign bus.ls_rvalid_o = w_ls_rvalid;
    assign bus.if_rdata_o  = w_if_rvalid ? bus.ram_rdata_i : '0;
    assign bus.ls_rdata_o  = w_ls_rvalid ? bus.ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Two arbiters (RD_LATENCY 1 and 3) share identical requester stimulus.
// A behavioural model (request flags, a preferred-requester bit, a word
// memory) predicts grants and RAM drive each cycle; read returns are
// queued per DUT with their due cycle and checked by a separate monitor.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;
`ifdef ARB_LSU_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef struct {
        int          due;
        logic        own;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.XLEN(XLEN)) bus_a ();
    ram_port_arbiter_if #(.XLEN(XLEN)) bus_b ();

    ram_port_arbiter #(.XLEN(XLEN), .RD_LATENCY(LAT_A)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    ram_port_arbiter #(.XLEN(XLEN), .RD_LATENCY(LAT_B)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pending requests as seen by the requesters
    logic        p_if;
    logic [63:0] p_if_addr;
    logic        p_ls;
    logic        p_ls_wen;
    logic [63:0] p_ls_addr;
    logic [7:0]  p_ls_be;
    logic [63:0] p_ls_wdata;

    // Model state
    logic        last_win_lsu;
    logic [63:0] mem [logic [60:0]];
    logic [63:0] hist [4];
    exp_t        eq [2][$];
    logic        e_gif, e_gls, e_ren, e_wen;
    logic [63:0] e_addr, e_wd;
    logic [7:0]  e_be;
    logic [1:0]  dut_gnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [60:0] w);
        if (mem.exists(w)) return mem[w];
        return {3'b000, w} ^ 64'h5A5A_0F0F_C3C3_9696;
    endfunction

    task automatic mem_wr(input logic [60:0] w, input logic [7:0] be, input logic [63:0] wd);
        logic [63:0] v;
        v = mem_rd(w);
        for (int b = 0; b < 8; b++) begin
            if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
        end
        mem[w] = v;
    endtask

    function automatic logic [63:0] rand_addr();
        return 64'($urandom_range(0, 127));
    endfunction

    task automatic apply_inputs();
        bus_a.if_req_i = p_if;       bus_b.if_req_i = p_if;
        bus_a.if_addr_i = p_if_addr; bus_b.if_addr_i = p_if_addr;
        bus_a.ls_req_i = p_ls;       bus_b.ls_req_i = p_ls;
        bus_a.ls_wen_i = p_ls_wen;   bus_b.ls_wen_i = p_ls_wen;
        bus_a.ls_addr_i = p_ls_addr; bus_b.ls_addr_i = p_ls_addr;
        bus_a.ls_byte_en_i = p_ls_be; bus_b.ls_byte_en_i = p_ls_be;
        bus_a.ls_wdata_i = p_ls_wdata; bus_b.ls_wdata_i = p_ls_wdata;
    endtask

    task automatic cmp_dut(input string t, input logic ig, input logic lg, input logic ren,
                           input logic wen, input logic [63:0] addr, input logic [7:0] be,
                           input logic [63:0] wd);
        chk({t, "_if_gnt"}, 64'(ig), 64'(e_gif));
        chk({t, "_ls_gnt"}, 64'(lg), 64'(e_gls));
        chk({t, "_ram_ren"}, 64'(ren), 64'(e_ren));
        chk({t, "_ram_wen"}, 64'(wen), 64'(e_wen));
        chk({t, "_ram_addr"}, addr, e_addr);
        chk({t, "_ram_byte_en"}, 64'(be), 64'(e_be));
        chk({t, "_ram_wdata"}, wd, e_wd);
    endtask

    // One clock: predict and check this cycle, then advance to next cycle's inputs
    task automatic step();
        logic        want_if, want_ls;
        logic [63:0] d;
        exp_t        e;
        @(negedge clk);
        want_if = p_if & rst_n;
        want_ls = p_ls & rst_n;
        e_gif = 1'b0; e_gls = 1'b0; e_ren = 1'b0; e_wen = 1'b0;
        e_addr = '0; e_be = '0; e_wd = '0;
        d = {$urandom, $urandom};
        if (want_if && want_ls) begin
            if (PRIO) e_gls = 1'b1;
            else if (last_win_lsu) e_gif = 1'b1;
            else e_gls = 1'b1;
        end else begin
            e_gif = want_if;
            e_gls = want_ls;
        end
        if (e_gif) begin
            e_ren  = 1'b1;
            e_addr = p_if_addr & ~64'h7;
            d      = mem_rd(p_if_addr[63:3]);
        end
        if (e_gls) begin
            e_addr = p_ls_addr & ~64'h7;
            if (p_ls_wen) begin
                e_wen = 1'b1;
                e_be  = p_ls_be;
                e_wd  = p_ls_wdata;
            end else begin
                e_ren = 1'b1;
                d     = mem_rd(p_ls_addr[63:3]);
            end
        end
        if (e_gif || e_gls) last_win_lsu = e_gls;
        dut_gnt = {bus_a.ls_gnt_o, bus_a.if_gnt_o};
        cmp_dut("a", bus_a.if_gnt_o, bus_a.ls_gnt_o, bus_a.ram_ren_o, bus_a.ram_wen_o,
                bus_a.ram_addr_o, bus_a.ram_byte_en_o, bus_a.ram_wdata_o);
        cmp_dut("b", bus_b.if_gnt_o, bus_b.ls_gnt_o, bus_b.ram_ren_o, bus_b.ram_wen_o,
                bus_b.ram_addr_o, bus_b.ram_byte_en_o, bus_b.ram_wdata_o);
        if (e_wen) mem_wr(p_ls_addr[63:3], p_ls_be, p_ls_wdata);
        if (e_ren) begin
            e.own  = e_gls;
            e.data = d;
            e.due  = cyc + int'(LAT_A);
            eq[0].push_back(e);
            e.due  = cyc + int'(LAT_B);
            eq[1].push_back(e);
        end
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
        bus_a.ram_rdata_i = hist[LAT_A-1];
        bus_b.ram_rdata_i = hist[LAT_B-1];
        if (e_gif) p_if = 1'b0;
        if (e_gls) p_ls = 1'b0;
        apply_inputs();
    endtask

    task automatic reset_for(input int n);
        rst_n = 1'b0;
        eq[0].delete();
        eq[1].delete();
        last_win_lsu = 1'b1;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        repeat (6) step();
    endtask

    // Read-return monitor for one DUT
    task automatic mon(input int k, input logic irv, input logic [63:0] ird,
                       input logic lrv, input logic [63:0] lrd);
        exp_t  e;
        string t;
        t = (k == 0) ? "a" : "b";
        while (eq[k].size() > 0 && eq[k][0].due < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_rvalid_missing: expected at cycle %0d, not returned (now %0d)",
                     t, eq[k][0].due, cyc);
            void'(eq[k].pop_front());
        end
        if (irv && lrv) chk({t, "_rvalid_both"}, 64'(1), 64'(0));
        if (irv || lrv) begin
            if (eq[k].size() == 0) begin
                chk({t, "_rvalid_unexpected"}, {62'd0, lrv, irv}, 64'd0);
            end else begin
                e = eq[k].pop_front();
                chk({t, "_rvalid_cycle"}, 64'(cyc), 64'(e.due));
                chk({t, "_rvalid_owner"}, 64'(lrv), 64'(e.own));
                chk({t, "_rdata"}, lrv ? lrd : ird, e.data);
            end
        end
        if (!irv) chk({t, "_if_rdata_idle"}, ird, 64'd0);
        if (!lrv) chk({t, "_ls_rdata_idle"}, lrd, 64'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, bus_a.if_rvalid_o, bus_a.if_rdata_o, bus_a.ls_rvalid_o, bus_a.ls_rdata_o);
            mon(1, bus_b.if_rvalid_o, bus_b.if_rdata_o, bus_b.ls_rvalid_o, bus_b.ls_rdata_o);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        p_if = 1'b0; p_if_addr = '0; p_ls = 1'b0; p_ls_wen = 1'b0;
        p_ls_addr = '0; p_ls_be = '0; p_ls_wdata = '0;
        last_win_lsu = 1'b1;
        for (int i = 0; i < 4; i++) hist[i] = '0;
        bus_a.ram_rdata_i = '0;
        bus_b.ram_rdata_i = '0;
        apply_inputs();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        mon_en = 1'b1;

        // Requests held through reset must be masked; IFU wins first contention after
        p_if = 1'b1; p_if_addr = 64'h48;
        p_ls = 1'b1; p_ls_wen = 1'b1; p_ls_addr = 64'h10; p_ls_be = 8'hFF;
        p_ls_wdata = 64'h0123_4567_89AB_CDEF;
        apply_inputs();
        @(posedge clk);
        #1;
        reset_for(2);
        step();
        chk("reset_first_contention", 64'(dut_gnt), PRIO ? 64'd2 : 64'd1);
        drain();

        // IFU alone, unaligned address
        mem[61'h200] = 64'hDEAD_BEEF_CAFE_F00D;
        p_if = 1'b1; p_if_addr = 64'h1004;
        apply_inputs();
        step();
        chk("ifu_alone_gnt", 64'(dut_gnt), 64'd1);
        drain();

        // Both requesting continuously from reset, LSU reading
        reset_for(1);
        for (int i = 0; i < 6; i++) begin
            if (!p_if) begin p_if = 1'b1; p_if_addr = rand_addr(); end
            if (!p_ls) begin p_ls = 1'b1; p_ls_wen = 1'b0; p_ls_addr = rand_addr(); end
            apply_inputs();
            step();
            chk("contention_seq", 64'(dut_gnt), (PRIO || (i % 2 == 1)) ? 64'd2 : 64'd1);
        end
        drain();

        // LSU partial write then read of the same word
        p_ls = 1'b1; p_ls_wen = 1'b1; p_ls_addr = 64'h8; p_ls_be = 8'h0F;
        p_ls_wdata = 64'h1122_3344_1122_3344;
        apply_inputs();
        step();
        p_ls = 1'b1; p_ls_wen = 1'b0; p_ls_addr = 64'h8;
        apply_inputs();
        step();
        drain();

        // Back-to-back reads IFU, LSU, IFU
        reset_for(1);
        p_if = 1'b1; p_if_addr = 64'h20;
        p_ls = 1'b1; p_ls_wen = 1'b0; p_ls_addr = 64'h28;
        apply_inputs();
        step();
        if (!p_if) begin p_if = 1'b1; p_if_addr = 64'h30; end
        apply_inputs();
        step();
        step();
        drain();

        // Reset while reads are in flight
        p_if = 1'b1; p_if_addr = 64'h38;
        apply_inputs();
        step();
        reset_for(1);
        p_if = 1'b1; p_if_addr = 64'h40;
        p_ls = 1'b1; p_ls_wen = 1'b0; p_ls_addr = 64'h50;
        apply_inputs();
        step();
        chk("post_reset_contention", 64'(dut_gnt), PRIO ? 64'd2 : 64'd1);
        drain();

`ifdef ARB_LSU_PRIO_EN
        // LSU keeps requesting for 4 grants, IFU waits until it drops
        for (int i = 0; i < 5; i++) begin
            if (i < 4 && !p_ls) begin p_ls = 1'b1; p_ls_wen = 1'b0; p_ls_addr = rand_addr(); end
            if (i == 0) begin p_if = 1'b1; p_if_addr = rand_addr(); end
            apply_inputs();
            step();
            chk("prio_seq", 64'(dut_gnt), (i < 4) ? 64'd2 : 64'd1);
        end
        drain();
`endif

        // Random traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if (!p_if && $urandom_range(0, 99) < 60) begin
                p_if = 1'b1; p_if_addr = rand_addr();
            end
            if (!p_ls && $urandom_range(0, 99) < 60) begin
                p_ls = 1'b1;
                p_ls_wen = 1'($urandom_range(0, 1));
                p_ls_addr = rand_addr();
                p_ls_be = 8'($urandom);
                p_ls_wdata = {$urandom, $urandom};
            end
            apply_inputs();
            if ($urandom_range(0, 299) == 0) reset_for(1 + $urandom_range(0, 1));
            else step();
        end
        drain();

        chk("a_queue_empty", 64'(eq[0].size()), 64'd0);
        chk("b_queue_empty", 64'(eq[1].size()), 64'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
